// File: rtl/if_pkg.sv
// if_pkg: shared types, constants and helpers for the instruction-fetch front end.
// Queue entries carry a PC of PC_MAX_W bits; the top narrows or widens to XLEN.
package if_pkg;

   localparam int ILEN     = 32;
   localparam int PC_MAX_W = 64;

   // Data-phase tracker: nothing outstanding, data wanted, or data to be thrown away
   typedef enum logic [1:0] {
      DP_IDLE = 2'd0,
      DP_LIVE = 2'd1,
      DP_DROP = 2'd2
   } dp_state_t;

   typedef struct packed {
      logic [PC_MAX_W-1:0] pc;
      logic [ILEN-1:0]     inst;
   } if_entry_t;

   // Index of the 32-bit instruction slot inside a bus word of bus_w bits
   function automatic logic [31:0] word_index(input logic [PC_MAX_W-1:0] pc,
                                              input logic [31:0]         bus_w);
      logic [31:0] w_mask;
      w_mask = (bus_w / 32'(ILEN)) - 32'd1;
      return 32'(pc >> 32'd2) & w_mask;
   endfunction

endpackage

// File: rtl/if_queue.sv
// if_queue: synchronous prefetch FIFO of if_entry_t with a single-cycle flush.
// No bypass path: the head is always a stored entry.
module if_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  if_entry_t                i_push_entry,
   input  logic                     i_pop,
   output if_entry_t                o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   if_entry_t     r_mem [DEPTH];

   logic w_push_ok;
   logic w_pop_ok;

   // A push into a full queue or a pop from an empty one is refused outright
   assign w_push_ok = i_push && (r_count != FULL_C);
   assign w_pop_ok  = i_pop  && (r_count != {CW{1'b0}});

   // Pointer and occupancy bookkeeping; reset and flush both return to empty
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1'b1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1'b1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1'b1);
            2'b01:   r_count <= r_count - CW'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; written only by a push that is not voided by reset/flush
   always_ff @(posedge i_clk) begin
      if (w_push_ok && !i_reset && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_entry;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: pipelined instruction-fetch front end. Issues one read per
// cycle while queue credit allows, extracts the 32-bit instruction from the
// bus word, and buffers it for decode. Redirects flush the queue and turn any
// outstanding data phase into a discard.
// Optional macro IF_BYPASS_EN: when the queue is empty, a live data phase is
// presented to decode in the same cycle it completes.
module inst_prefetch
   import if_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              BUS_W    = 64,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic              CLK,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic [XLEN-1:0]   HADDR,
   output logic              HTRANS,
   input  logic              HREADY,
   input  logic [BUS_W-1:0]  HRDATA,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ILEN-1:0]   out_inst,
   output logic [XLEN-1:0]   out_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_dp_pc;
   dp_state_t       r_dp_state;

   logic [CW-1:0]   w_count;
   logic [CW:0]     w_credit;
   logic            w_accept;
   logic            w_complete;
   logic            w_data_live;
   logic            w_q_valid;
   logic            w_push;
   logic            w_pop;
   logic [31:0]     w_word_idx;
   logic [ILEN-1:0] w_inst;
   logic [XLEN-1:0] w_redirect_pc;
   if_entry_t       w_head;
   if_entry_t       w_push_entry;

   // Credit counts queued entries plus a data phase that will push; pops are not credited
   assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, (r_dp_state == DP_LIVE)};

   assign HTRANS = !reset && (w_credit < DEPTH_C);
   assign HADDR  = reset ? RESET_PC : r_fetch_pc;

   assign w_accept    = HTRANS && HREADY;
   assign w_complete  = (r_dp_state != DP_IDLE) && HREADY;
   assign w_data_live = w_complete && (r_dp_state == DP_LIVE) && !redirect_valid && !reset;
   assign w_q_valid   = !reset && (w_count != {CW{1'b0}});

   // Low two bits of the redirect target are forced to zero
   assign w_redirect_pc = redirect_pc & ~XLEN'(2'd3);

   // Instruction slot selected by the data-phase PC
   assign w_word_idx = word_index(PC_MAX_W'(r_dp_pc), 32'(BUS_W));
   assign w_inst     = ILEN'(HRDATA >> (w_word_idx * 32'(ILEN)));

   assign w_push_entry.pc   = PC_MAX_W'(r_dp_pc);
   assign w_push_entry.inst = w_inst;

   // A pop in the redirect cycle is void; the flush wins
   assign w_pop = w_q_valid && out_ready && !redirect_valid;

`ifdef IF_BYPASS_EN
   logic w_bypass;

   assign w_bypass = !reset && (w_count == {CW{1'b0}}) && (r_dp_state == DP_LIVE)
                     && HREADY && !redirect_valid;

   // Head comes straight from the bus when the queue is empty and data is arriving
   always_comb begin
      if (w_bypass) begin
         out_valid = 1'b1;
         out_pc    = r_dp_pc;
         out_inst  = w_inst;
      end else begin
         out_valid = w_q_valid;
         out_pc    = XLEN'(w_head.pc);
         out_inst  = w_head.inst;
      end
   end

   // Bypassed data that decode takes this cycle never enters the queue
   assign w_push = w_data_live && !(w_bypass && out_ready);
`else
   assign out_valid = w_q_valid;
   assign out_pc    = XLEN'(w_head.pc);
   assign out_inst  = w_head.inst;
   assign w_push    = w_data_live;
`endif

   // Fetch address, data-phase PC and data-phase tracker
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_dp_pc    <= RESET_PC;
         r_dp_state <= DP_IDLE;
      end else begin
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
         end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(3'd4);
         end else begin
            r_fetch_pc <= r_fetch_pc;
         end

         if (w_accept) begin
            r_dp_pc <= r_fetch_pc;
         end else begin
            r_dp_pc <= r_dp_pc;
         end

         case (r_dp_state)
            DP_IDLE: begin
               if (w_accept) begin
                  r_dp_state <= redirect_valid ? DP_DROP : DP_LIVE;
               end else begin
                  r_dp_state <= DP_IDLE;
               end
            end
            DP_LIVE: begin
               if (w_accept) begin
                  r_dp_state <= redirect_valid ? DP_DROP : DP_LIVE;
               end else if (w_complete) begin
                  r_dp_state <= DP_IDLE;
               end else if (redirect_valid) begin
                  r_dp_state <= DP_DROP;
               end else begin
                  r_dp_state <= DP_LIVE;
               end
            end
            DP_DROP: begin
               if (w_accept) begin
                  r_dp_state <= redirect_valid ? DP_DROP : DP_LIVE;
               end else if (w_complete) begin
                  r_dp_state <= DP_IDLE;
               end else begin
                  r_dp_state <= DP_DROP;
               end
            end
            default: r_dp_state <= DP_IDLE;
         endcase
      end
   end

   if_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk        (CLK),
      .i_reset      (reset),
      .i_flush      (redirect_valid),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_count      (w_count)
   );

endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed bench for inst_prefetch with a small AHB-lite read slave.
module tb_inst_prefetch;

`ifdef IF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        CLK;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] HADDR;
   logic        HTRANS;
   logic        HREADY;
   logic [63:0] HRDATA;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] got_pc[$];
   logic [31:0] got_inst[$];
   logic [63:0] addr_q[$];

   logic        s_dp_valid;
   logic [63:0] s_dp_addr;

   inst_prefetch #(.XLEN(64), .BUS_W(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
      .CLK            (CLK),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .HADDR          (HADDR),
      .HTRANS         (HTRANS),
      .HREADY         (HREADY),
      .HRDATA         (HRDATA),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // instruction stored at a 4-byte aligned PC
   function automatic logic [31:0] inst_for(input logic [63:0] pc);
      if (pc == 64'h0) return 32'h00100093;
      else if (pc == 64'h4) return 32'h00000013;
      else return {16'hC0DE, pc[15:0]};
   endfunction

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [63:0] b;
      b = {a[63:3], 3'b000};
      return {inst_for(b + 64'd4), inst_for(b)};
   endfunction

   // slave: captures the address phase, serves data in the following data phase
   always @(posedge CLK) begin
      if (reset) begin
         s_dp_valid <= 1'b0;
         s_dp_addr  <= 64'h0;
      end else if (HREADY) begin
         s_dp_valid <= HTRANS;
         s_dp_addr  <= HADDR;
      end
   end
   assign HRDATA = mem_word(s_dp_addr);

   // monitor: 1 time unit before each rising edge, log handshakes and address phases
   always @(negedge CLK) begin
      #4;
      if (!reset && out_valid && out_ready && !redirect_valid) begin
         got_pc.push_back(out_pc);
         got_inst.push_back(out_inst);
      end
      if (!reset && HTRANS && HREADY) addr_q.push_back(HADDR);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_reset(input logic rdy);
      @(negedge CLK);
      reset = 1'b1; redirect_valid = 1'b0; HREADY = 1'b1; out_ready = rdy;
      repeat (2) @(negedge CLK);
      got_pc.delete(); got_inst.delete(); addr_q.delete();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      #4;
      n_cmp++; if (HTRANS !== 1'b0) begin n_fail++; $display("FAIL rst_htrans: got %b expected 0", HTRANS); end
      n_cmp++; if (HADDR !== 64'h0) begin n_fail++; $display("FAIL rst_haddr: got %h expected 0", HADDR); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      do_reset(1'b1);
      #4;
      n_cmp++; if (HTRANS !== 1'b1) begin n_fail++; $display("FAIL rel_htrans: got %b expected 1", HTRANS); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_stream();
      int exp_n;
      do_reset(1'b1);
      repeat (12) @(negedge CLK);
      exp_n = BYP ? 11 : 10;
      n_cmp++; if (got_pc.size() != exp_n) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d", got_pc.size(), exp_n); end
      n_cmp++; if (got_inst[0] !== 32'h00100093) begin n_fail++; $display("FAIL stream_inst0: got %h expected 00100093", got_inst[0]); end
      n_cmp++; if (got_inst[1] !== 32'h00000013) begin n_fail++; $display("FAIL stream_inst1: got %h expected 00000013", got_inst[1]); end
      for (int i = 0; i < got_pc.size(); i++) begin
         n_cmp++;
         if (got_pc[i] !== 64'(4*i) || got_inst[i] !== inst_for(64'(4*i))) begin
            n_fail++; $display("FAIL stream_seq[%0d]: got %h/%h expected %h/%h", i, got_pc[i], got_inst[i], 64'(4*i), inst_for(64'(4*i)));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      repeat (20) @(negedge CLK);
      #4;
      n_cmp++; if (addr_q.size() != 4) begin n_fail++; $display("FAIL bp_addr_count: got %0d expected 4", addr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (addr_q[i] !== 64'(4*i)) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, addr_q[i], 64'(4*i)); end
      end
      n_cmp++; if (HTRANS !== 1'b0) begin n_fail++; $display("FAIL bp_htrans: got %b expected 0", HTRANS); end
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin n_fail++; $display("FAIL bp_head: got %b/%h expected 1/0", out_valid, out_pc); end
      n_cmp++; if (got_pc.size() != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d expected 0", got_pc.size()); end
      @(negedge CLK);
      out_ready = 1'b1;
      repeat (8) @(negedge CLK);
      n_cmp++; if (got_pc.size() < 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected >=6", got_pc.size()); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (got_pc[i] !== 64'(4*i)) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h expected %h", i, got_pc[i], 64'(4*i)); end
      end
   endtask

   task automatic test_redirect();
      bit found;
      int idx;
      int bad;
      logic [63:0] exp_last;
      do_reset(1'b1);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (s_dp_valid && s_dp_addr == 64'h20) begin found = 1'b1; break; end
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL redir_wait: got no data phase for 20 expected one"); end
      redirect_valid = 1'b1; redirect_pc = 64'h1002;
      @(negedge CLK);
      redirect_valid = 1'b0;
      #4;
      n_cmp++; if (HADDR !== 64'h1000 || HTRANS !== 1'b1) begin n_fail++; $display("FAIL redir_haddr: got %h/%b expected 1000/1", HADDR, HTRANS); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_r_valid: got %b expected 0", out_valid); end
      @(negedge CLK);
      #4;
      n_cmp++; if (out_valid !== BYP) begin n_fail++; $display("FAIL redir_r1_valid: got %b expected %b", out_valid, BYP); end
      @(negedge CLK);
      #4;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== (BYP ? 64'h1004 : 64'h1000)) begin
         n_fail++; $display("FAIL redir_r2_head: got %b/%h expected 1/%h", out_valid, out_pc, (BYP ? 64'h1004 : 64'h1000));
      end
      repeat (4) @(negedge CLK);
      idx = -1; bad = 0;
      for (int i = 0; i < got_pc.size(); i++) begin
         if (got_pc[i] == 64'h1000 && idx < 0) idx = i;
         if (got_pc[i] == 64'h20 || got_pc[i] == 64'h24) bad++;
      end
      exp_last = BYP ? 64'h1C : 64'h18;
      n_cmp++; if (idx < 1) begin n_fail++; $display("FAIL redir_found: got index %0d expected >=1", idx); end
      else begin
         n_cmp++; if (got_pc[idx-1] !== exp_last) begin n_fail++; $display("FAIL redir_last_old: got %h expected %h", got_pc[idx-1], exp_last); end
         n_cmp++; if (got_inst[idx] !== 32'hC0DE1000) begin n_fail++; $display("FAIL redir_inst: got %h expected C0DE1000", got_inst[idx]); end
         n_cmp++; if (got_pc[idx+1] !== 64'h1004 || got_inst[idx+1] !== 32'hC0DE1004) begin
            n_fail++; $display("FAIL redir_next: got %h/%h expected 1004/C0DE1004", got_pc[idx+1], got_inst[idx+1]);
         end
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL redir_dropped: got %0d stale entries expected 0", bad); end
   endtask

   task automatic test_wait_states();
      do_reset(1'b1);
      repeat (6) @(negedge CLK);
      HREADY = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #4;
         n_cmp++; if (HADDR !== 64'h18 || HTRANS !== 1'b1) begin n_fail++; $display("FAIL ws_hold[%0d]: got %h/%b expected 18/1", c, HADDR, HTRANS); end
         @(negedge CLK);
      end
      HREADY = 1'b1;
      repeat (10) @(negedge CLK);
      n_cmp++; if (got_pc.size() < 8) begin n_fail++; $display("FAIL ws_count: got %0d expected >=8", got_pc.size()); end
      for (int i = 0; i < got_pc.size(); i++) begin
         n_cmp++; if (got_pc[i] !== 64'(4*i)) begin n_fail++; $display("FAIL ws_order[%0d]: got %h expected %h", i, got_pc[i], 64'(4*i)); end
      end
      for (int i = 0; i < addr_q.size(); i++) begin
         n_cmp++; if (addr_q[i] !== 64'(4*i)) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h expected %h", i, addr_q[i], 64'(4*i)); end
      end
   endtask

   task automatic test_redirect_pop();
      int bad;
      do_reset(1'b0);
      repeat (4) @(negedge CLK);
      redirect_valid = 1'b1; redirect_pc = 64'h2000; out_ready = 1'b1;
      #4;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || HTRANS !== 1'b0) begin
         n_fail++; $display("FAIL rp_setup: got %b/%h/%b expected 1/0/0", out_valid, out_pc, HTRANS);
      end
      @(negedge CLK);
      redirect_valid = 1'b0;
      #4;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rp_empty: got %b expected 0", out_valid); end
      n_cmp++; if (HADDR !== 64'h2000) begin n_fail++; $display("FAIL rp_haddr: got %h expected 2000", HADDR); end
      repeat (5) @(negedge CLK);
      bad = 0;
      for (int i = 0; i < got_pc.size(); i++) if (got_pc[i] < 64'h2000) bad++;
      n_cmp++; if (got_pc[0] !== 64'h2000) begin n_fail++; $display("FAIL rp_first: got %h expected 2000", got_pc[0]); end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rp_stale: got %0d stale entries expected 0", bad); end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      repeat (5) @(negedge CLK);
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #4;
         n_cmp++; if (HTRANS !== 1'b0 || out_valid !== 1'b0 || HADDR !== 64'h0) begin
            n_fail++; $display("FAIL mid_rst[%0d]: got %b/%b/%h expected 0/0/0", c, HTRANS, out_valid, HADDR);
         end
         @(negedge CLK);
      end
      got_pc.delete(); got_inst.delete(); addr_q.delete();
      reset = 1'b0;
      repeat (6) @(negedge CLK);
      n_cmp++; if (addr_q[0] !== 64'h0 || addr_q[1] !== 64'h4) begin n_fail++; $display("FAIL mid_restart_addr: got %h,%h expected 0,4", addr_q[0], addr_q[1]); end
      n_cmp++; if (got_pc[0] !== 64'h0 || got_inst[0] !== 32'h00100093) begin
         n_fail++; $display("FAIL mid_restart_out: got %h/%h expected 0/00100093", got_pc[0], got_inst[0]);
      end
   endtask

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; HREADY = 1'b1; out_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wait_states();
      test_redirect_pop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Parametrised instruction-fetch front end. It issues pipelined AHB-lite-style reads, extracts 32-bit instructions from the bus word, and buffers them in a DEPTH-entry prefetch queue. Decode consumes the queue through a valid/ready handshake. Redirects from execute flush the queue and discard any in-flight data phase. It sits between the instruction bus and decode, and replaces the single-register fetch stage with its global stall.

## Interface
- XLEN, 64: address/PC width
- BUS_W, 64: HRDATA width; multiple of 32, power of two
- DEPTH, 4: prefetch queue entries; power of two, ≥2
- RESET_PC, 0: fetch address after reset
---
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (forced 0)
- HADDR  out  XLEN  address-phase address
- HTRANS  out  1  1 = address phase valid (NONSEQ), 0 = IDLE
- HREADY  in  1  slave ready; low extends the current data phase and stalls the address phase
- HRDATA  in  BUS_W  read data, sampled when the data phase completes
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_inst  out  32  head instruction
- out_pc  out  XLEN  head PC

## Operation
- Registers:
  - fetch_pc
  - dp_pc
  - data-phase tracker dp_state ∈ {DP_IDLE, DP_LIVE, DP_DROP}
  - queue storage, rd/wr pointers, count (0..DEPTH)
- Reset: fetch_pc=RESET_PC, dp_state=DP_IDLE, count=0. While reset is high, HTRANS=0, HADDR=RESET_PC, out_valid=0.
- Issue condition: HTRANS = !reset && (count + (dp_state==DP_LIVE)) < DEPTH. Same-cycle pops are ignored (conservative credit). HADDR = fetch_pc.
- Address accept: HTRANS && HREADY at an edge.
  - fetch_pc += 4, dp_pc <= fetch_pc.
  - dp_state <= DP_LIVE, or DP_DROP if redirect_valid in the same cycle.
- Data complete: dp_state != DP_IDLE && HREADY at an edge.
  - DP_LIVE: push {dp_pc, HRDATA[32*dp_pc[log2(BUS_W/8)-1:2] +: 32]}.
  - DP_DROP: data discarded.
  - If no new address is accepted at that edge, dp_state <= DP_IDLE.
- Pop: out_valid && out_ready, with out_valid = (count != 0). Head fields are valid only while out_valid.
- Redirect at an edge:
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; this overrides +4.
  - count <= 0 and pointers reset; any push or pop in that cycle is void.
  - dp_state DP_LIVE → DP_DROP.
  - out_valid is not masked combinationally in the redirect cycle.
- Tracker transitions:
  - IDLE → LIVE/DROP on accept.
  - LIVE/DROP → IDLE on complete without accept.
  - LIVE/DROP → LIVE/DROP on complete with accept; the new state is set by redirect.
  - LIVE → DROP on redirect.
  - DROP never returns to LIVE without completing.
- Simultaneous push and pop with count==DEPTH cannot occur (credit rule). Push and pop in the same cycle leave count unchanged.
- Pointer wrap is natural modulo DEPTH.

## Timing
- Address phase at edge N, data phase at edge N+1 (if HREADY); throughput is 1 instruction/cycle with HREADY=1 and out_ready=1.
- Redirect at edge R: HADDR=redirect target during cycle R..R+1; accepted at R+1; data at R+2. Without bypass, out_valid first rises after R+2.
- Wait states: each HREADY-low cycle adds one cycle. HADDR/HTRANS are held stable while HREADY is low.
- Reset mid-operation: in-flight phase abandoned, no push; the slave shares the reset.

## Configuration
- IF_BYPASS_EN defined:
  - When count==0, dp_state==DP_LIVE, HREADY=1 and no redirect, out_valid=1 combinationally with the HRDATA-derived instruction/PC.
  - If out_ready, no push occurs.
  - Redirect-to-out_valid latency drops by one cycle (visible during cycle R+1..R+2).
- IF_BYPASS_EN undefined: all instructions pass through the queue; outputs are purely register/queue driven.

## Structure
- Package if_pkg holds:
  - dp_state_t enum (DP_IDLE, DP_LIVE, DP_DROP)
  - if_entry_t struct {pc, inst}
  - ILEN=32 constant
  - word-select helper function
- Sub-module if_queue: synchronous FIFO of if_entry_t, parameter DEPTH, with flush input. It has push/pop/count and no bypass; the bypass mux lives in inst_prefetch.

## Test plan
- Reset release, HREADY=1, out_ready=1, memory word at 0x0 = 0x00000013_00100093 → out_pc 0x0 inst 0x00100093, then 0x4 inst 0x00000013, one per cycle.
- out_ready=0 for 20 cycles, DEPTH=4 → exactly 4 address phases (0x0..0xC). HTRANS=0 afterwards, count=4, no overflow.
- Redirect to 0x1002 during the live data phase of 0x20 → data of 0x20 dropped; next HADDR 0x1000. First out_pc 0x1000 at R+2 (R+1 with IF_BYPASS_EN).
- HREADY low 3 cycles mid-stream → HADDR/HTRANS held, no duplicate or lost PCs, order preserved.
- Redirect and pop in the same cycle with count=3 → queue empty next cycle, no stale entries emitted.
- Synchronous reset asserted with a data phase live → next cycle HTRANS=0, out_valid=0, HADDR=RESET_PC. After release, fetch restarts at RESET_PC.
